// File: rtl/fir_seq_ctrl.sv
// Coefficient loader and sample pacer for the 4-tap FIR datapath.
// It shifts coefficients out MSB-first, then issues a sample enable every DIV cycles.
module fir_seq_ctrl #(
  parameter int NTAPS = 4,
  parameter int CW    = 8,
  parameter int DIV   = 4,
  parameter int UW    = 8
) (
  input  logic                  ph1,
  input  logic                  reset,
  input  logic                  coef_load,
  input  logic [NTAPS*CW-1:0]   coef_data,
  output logic                  coef_ready,
  output logic                  shift_en,
  output logic                  shift_in,
  output logic                  cfg_valid,
  input  logic                  sample_in_valid,
  output logic                  sample_in_ready,
  output logic                  sample_en,
  output logic [UW-1:0]         underrun_cnt
);
  localparam int NB = NTAPS * CW;
  localparam int BW = $clog2(NB);
  localparam int DW = $clog2(DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(NB - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NB-1:0]   sreg_q, sreg_d;
  logic            cfg_valid_q, cfg_valid_d;
  logic [UW-1:0]   underrun_q, underrun_d;
  logic            strobe, accept;

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      sreg_q      <= '0;
      cfg_valid_q <= 1'b0;
      underrun_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sreg_q      <= sreg_d;
      cfg_valid_q <= cfg_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sreg_d      = sreg_q;
    cfg_valid_d = cfg_valid_q;
    underrun_d  = underrun_q;
    coef_ready  = (state_q != LOAD);
    shift_en    = (state_q == LOAD);
    shift_in    = shift_en & sreg_q[NB-1];
    strobe      = (state_q == RUN) && (div_cnt_q == DIV_LAST);
    accept      = coef_load && coef_ready;
    // A reload accepted on a strobe cycle aborts that period entirely.
    sample_en       = strobe && sample_in_valid && !accept;
    sample_in_ready = sample_en;

    case (state_q)
      LOAD: begin
        sreg_d    = {sreg_q[NB-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BIT_LAST) begin
          state_d     = RUN;
          bit_cnt_d   = '0;
          div_cnt_d   = '0;
          cfg_valid_d = 1'b1;
        end
      end
      RUN: begin
        div_cnt_d = strobe ? '0 : div_cnt_q + DW'(1);
        if (strobe && !sample_in_valid && !accept && (underrun_q != '1))
          underrun_d = underrun_q + UW'(1);
      end
      default: ;
    endcase

    if (accept) begin
      state_d   = LOAD;
      sreg_d    = coef_data;
      bit_cnt_d = '0;
      div_cnt_d = '0;
    end
  end

  assign cfg_valid    = cfg_valid_q;
  assign underrun_cnt = underrun_q;
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: load, pacing, underruns, reload and reset mid-load.
// A second instance with UW=2 shares all inputs to exercise counter saturation.
module tb_fir_seq_ctrl;
  logic        ph1 = 1'b0;
  logic        reset;
  logic        coef_load;
  logic [31:0] coef_data;
  logic        sample_in_valid;
  logic        coef_ready, shift_en, shift_in, cfg_valid, sample_in_ready, sample_en;
  logic [7:0]  underrun_cnt;
  logic        s_coef_ready, s_shift_en, s_shift_in, s_cfg_valid, s_sample_in_ready, s_sample_en;
  logic [1:0]  s_underrun_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  fir_seq_ctrl u_dut (
    .ph1(ph1), .reset(reset), .coef_load(coef_load), .coef_data(coef_data),
    .coef_ready(coef_ready), .shift_en(shift_en), .shift_in(shift_in),
    .cfg_valid(cfg_valid), .sample_in_valid(sample_in_valid),
    .sample_in_ready(sample_in_ready), .sample_en(sample_en),
    .underrun_cnt(underrun_cnt)
  );

  fir_seq_ctrl #(.UW(2)) u_sat (
    .ph1(ph1), .reset(reset), .coef_load(coef_load), .coef_data(coef_data),
    .coef_ready(s_coef_ready), .shift_en(s_shift_en), .shift_in(s_shift_in),
    .cfg_valid(s_cfg_valid), .sample_in_valid(sample_in_valid),
    .sample_in_ready(s_sample_in_ready), .sample_en(s_sample_en),
    .underrun_cnt(s_underrun_cnt)
  );

  always #5 ph1 = ~ph1;

  // Edge monitor: deserialised coefficient chain, sample delay line, event counters.
  int          shift_cycles = 0;
  int          sen_cycles = 0;
  int          overlap = 0;
  logic [31:0] cap = '0;
  int          sample_val = 0;
  int          x0 = 0, x1 = 0, x2 = 0, x3 = 0;

  always @(posedge ph1) begin
    if (shift_en) begin
      shift_cycles++;
      cap = {cap[30:0], shift_in};
    end
    if (sample_en) begin
      sen_cycles++;
      x3 = x2; x2 = x1; x1 = x0; x0 = sample_val;
    end
    if (shift_en && sample_en) overlap++;
  end

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; coef_load = 1'b0; coef_data = '0; sample_in_valid = 1'b0;
    tick(); tick();
    total_cnt++;
    if (coef_ready !== 1'b1) $display("FAIL reset_coef_ready got %b exp 1", coef_ready); else pass_cnt++;
    total_cnt++;
    if ({shift_en, shift_in, cfg_valid, sample_en, sample_in_ready} !== 5'b0)
      $display("FAIL reset_outputs got %b exp 00000", {shift_en, shift_in, cfg_valid, sample_en, sample_in_ready});
    else pass_cnt++;
    total_cnt++;
    if (underrun_cnt !== 8'd0) $display("FAIL reset_underrun got %0d exp 0", underrun_cnt); else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  // Issues a one-cycle load, then walks the 32 shift cycles checking every bit.
  task automatic do_load(input logic [31:0] data, input int hold_cycles, input string tag);
    int s0, bad;
    s0 = shift_cycles; bad = 0;
    coef_data = data; coef_load = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      if (i >= hold_cycles) coef_load = 1'b0;
      #1;
      if (shift_en !== 1'b1 || shift_in !== data[31-i] || cfg_valid === 1'bx || sample_en !== 1'b0 || coef_ready !== 1'b0) begin
        if (bad == 0)
          $display("FAIL %s_bit%0d got en=%b in=%b sen=%b rdy=%b exp en=1 in=%b sen=0 rdy=0",
                   tag, i, shift_en, shift_in, sample_en, coef_ready, data[31-i]);
        bad++;
      end
      tick();
    end
    coef_load = 1'b0;
    total_cnt++;
    if (bad != 0) $display("FAIL %s_bits got %0d bad cycles exp 0", tag, bad); else pass_cnt++;
    total_cnt++;
    if (shift_en !== 1'b0 || cfg_valid !== 1'b1)
      $display("FAIL %s_done got en=%b cfg=%b exp en=0 cfg=1", tag, shift_en, cfg_valid);
    else pass_cnt++;
    total_cnt++;
    if (shift_cycles - s0 != 32) $display("FAIL %s_len got %0d exp 32", tag, shift_cycles - s0); else pass_cnt++;
    total_cnt++;
    if (cap !== data) $display("FAIL %s_chain got %h exp %h", tag, cap, data); else pass_cnt++;
  endtask

  task automatic test_load();
    total_cnt++;
    if (cfg_valid !== 1'b0) $display("FAIL pre_load_cfg got %b exp 0", cfg_valid); else pass_cnt++;
    do_load(32'h04030201, 1, "load");
  endtask

  task automatic test_run();
    int bad, y;
    bad = 0;
    sample_in_valid = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      sample_val = 10 * ((c + 3) / 4);
      #1;
      if (sample_en !== (c % 4 == 0) || sample_in_ready !== (c % 4 == 0)) begin
        $display("FAIL run_cycle%0d got sen=%b rdy=%b exp %0d", c, sample_en, sample_in_ready, c % 4 == 0);
        bad++;
      end
      tick();
    end
    total_cnt++;
    if (bad != 0) $display("FAIL run_pacing got %0d bad cycles exp 0", bad); else pass_cnt++;
    y = int'(cap[7:0]) * x0 + int'(cap[15:8]) * x1 + int'(cap[23:16]) * x2 + int'(cap[31:24]) * x3;
    total_cnt++;
    if (y != 200) $display("FAIL fir_y got %0d exp 200", y); else pass_cnt++;
  endtask

  task automatic test_underrun();
    int s0;
    s0 = sen_cycles;
    sample_in_valid = 1'b0;
    repeat (12) tick();
    total_cnt++;
    if (underrun_cnt !== 8'd3 || s_underrun_cnt !== 2'd3)
      $display("FAIL underrun3 got %0d/%0d exp 3/3", underrun_cnt, s_underrun_cnt);
    else pass_cnt++;
    total_cnt++;
    if (sen_cycles != s0) $display("FAIL underrun_no_sen got %0d exp 0", sen_cycles - s0); else pass_cnt++;
    sample_in_valid = 1'b1;
    repeat (3) tick();
    #1;
    total_cnt++;
    if (sample_en !== 1'b1) $display("FAIL late_sample got %b exp 1", sample_en); else pass_cnt++;
    tick();
    sample_in_valid = 1'b0;
    repeat (20) tick();
    total_cnt++;
    if (underrun_cnt !== 8'd8) $display("FAIL underrun8 got %0d exp 8", underrun_cnt); else pass_cnt++;
    total_cnt++;
    if (s_underrun_cnt !== 2'd3) $display("FAIL underrun_sat got %0d exp 3", s_underrun_cnt); else pass_cnt++;
  endtask

  task automatic test_reload();
    int s0;
    sample_in_valid = 1'b1;
    tick(); tick();
    s0 = sen_cycles;
    total_cnt++;
    if (coef_ready !== 1'b1) $display("FAIL reload_ready got %b exp 1", coef_ready); else pass_cnt++;
    do_load(32'h0A0B0C0D, 5, "reload");
    total_cnt++;
    if (sen_cycles != s0) $display("FAIL reload_aborted got %0d exp 0", sen_cycles - s0); else pass_cnt++;
    for (int c = 1; c <= 4; c++) begin
      #1;
      total_cnt++;
      if (sample_en !== (c == 4)) $display("FAIL reload_strobe%0d got %b exp %0d", c, sample_en, c == 4); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_reset_mid_load();
    int s0;
    coef_data = 32'h11223344; coef_load = 1'b1;
    tick();
    coef_load = 1'b0;
    repeat (17) tick();
    total_cnt++;
    if (shift_en !== 1'b1) $display("FAIL midload_active got %b exp 1", shift_en); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (shift_en !== 1'b0 || cfg_valid !== 1'b0 || coef_ready !== 1'b1 || underrun_cnt !== 8'd0)
      $display("FAIL async_reset got en=%b cfg=%b rdy=%b ur=%0d exp 0 0 1 0", shift_en, cfg_valid, coef_ready, underrun_cnt);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    sample_in_valid = 1'b1;
    s0 = sen_cycles;
    repeat (12) tick();
    total_cnt++;
    if (sen_cycles != s0 || underrun_cnt !== 8'd0)
      $display("FAIL idle_no_sen got sen=%0d ur=%0d exp 0 0", sen_cycles - s0, underrun_cnt);
    else pass_cnt++;
    do_load(32'h04030201, 1, "post_reset");
    s0 = sen_cycles;
    repeat (3) tick();
    #1;
    total_cnt++;
    if (sample_en !== 1'b1 || sen_cycles != s0)
      $display("FAIL post_reset_strobe got sen=%b prior=%0d exp 1 0", sample_en, sen_cycles - s0);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load();
    test_run();
    test_underrun();
    test_reload();
    test_reset_mid_load();
    total_cnt++;
    if (overlap != 0) $display("FAIL shift_sample_overlap got %0d exp 0", overlap); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
